coeff_sequencer: RTL

COEFF_SEQUENCER -- requirements
Module: coeff_sequencer

---
 rtl/coeff_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/coeff_sequencer.sv
// Coefficient sequencer: replays a loaded coefficient FIFO once per operand,
// hiding FIFO read latency behind a small skid buffer in front of the MAC.
module coeff_sequencer #(
   parameter int RAM_WIDTH  = 32,
   parameter int ADDR_LINES = 4,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  load_done_i,
   input  logic [ADDR_LINES:0]   ncoeff_i,
   input  logic                  fifo_empty_i,
   input  logic [RAM_WIDTH-1:0]  fifo_data_i,
   output logic                  fifo_rd_en_o,
   output logic                  fifo_redo_o,
   input  logic                  x_valid_i,
   input  logic [RAM_WIDTH-1:0]  x_i,
   output logic                  x_ready_o,
   input  logic                  mac_ready_i,
   output logic                  coeff_valid_o,
   output logic [RAM_WIDTH-1:0]  coeff_o,
   output logic [RAM_WIDTH-1:0]  x_o,
   output logic                  coeff_first_o,
   output logic                  coeff_last_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int CW    = ADDR_LINES + 1;
   localparam int DEPTH = READ_LAT + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int OW    = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] MAXN  = CW'(1 << ADDR_LINES);
   localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
   localparam logic [OW:0]   ROOM  = (OW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      ISSUE,
      DRAIN,
      REWIND
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        issued;
   logic [CW-1:0]        beat;
   logic [READ_LAT-1:0]  pipe;
   logic [READ_LAT-1:0]  pipe_nx;
   logic [OW-1:0]        infl;
   logic [OW-1:0]        occ;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [RAM_WIDTH-1:0] mem [DEPTH];
   logic [RAM_WIDTH-1:0] x_q;
   logic                 err_q;
   logic                 done_q;
   logic                 redo_q;
   logic                 xrdy_q;

   logic                 push;
   logic                 pop;
   logic                 rd_en;
   logic                 load_ok;
   logic                 last_beat;
   logic [OW:0]          pend;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PLAST) ? '0 : p + 1'b1;
   endfunction

   // Bit i set = a read issued i+1 cycles ago; the MSB lands this cycle.
   always_comb begin
      pipe_nx    = pipe << 1;
      pipe_nx[0] = rd_en;
   end

   assign push      = pipe[READ_LAT-1];
   assign pop       = (occ != '0) && mac_ready_i;
   // Credit the beat leaving this cycle so a full-rate stream never bubbles.
   assign pend      = {1'b0, infl} + {1'b0, occ} - {{OW{1'b0}}, pop};
   assign rd_en     = (state == ISSUE) && (issued < cnt) && (pend < ROOM);
   assign load_ok   = (ncoeff_i != '0) && (ncoeff_i <= MAXN) && !fifo_empty_i;
   assign last_beat = pop && (beat == cnt - 1'b1);

   assign fifo_rd_en_o  = rd_en;
   assign fifo_redo_o   = redo_q;
   assign x_ready_o     = xrdy_q;
   assign coeff_valid_o = (occ != '0);
   assign coeff_o       = mem[rd_ptr];
   assign x_o           = x_q;
   assign coeff_first_o = coeff_valid_o && (beat == '0);
   assign coeff_last_o  = coeff_valid_o && (beat == cnt - 1'b1);
   assign done_o        = done_q;
   assign err_o         = err_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state  <= IDLE;
         cnt    <= '0;
         issued <= '0;
         beat   <= '0;
         pipe   <= '0;
         infl   <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         x_q    <= '0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
         redo_q <= 1'b0;
         xrdy_q <= 1'b0;
      end else begin
         pipe <= pipe_nx;
         infl <= infl + OW'(rd_en) - OW'(push);
         occ  <= occ + OW'(push) - OW'(pop);
         if (push) begin
            mem[wr_ptr] <= fifo_data_i;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= nxt(rd_ptr);
            beat   <= beat + 1'b1;
         end
         if (rd_en) begin
            issued <= issued + 1'b1;
         end
         done_q <= 1'b0;
         redo_q <= 1'b0;
         if (load_done_i && ((state != IDLE) || !load_ok)) begin
            err_q <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (load_done_i && load_ok) begin
                  cnt    <= ncoeff_i;
                  xrdy_q <= 1'b1;
                  state  <= ARMED;
               end
            end
            ARMED: begin
               if (x_valid_i) begin
                  x_q    <= x_i;
                  xrdy_q <= 1'b0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (rd_en && (issued == cnt - 1'b1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_beat) begin
                  done_q <= 1'b1;
                  redo_q <= 1'b1;
                  state  <= REWIND;
               end
            end
            REWIND: begin
               issued <= '0;
               beat   <= '0;
               xrdy_q <= 1'b1;
               state  <= ARMED;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
